// File: rtl/alu_pkg.sv
// Shared decode definitions for the ALU issue stage: opcodes, funct3 codes,
// the decoded-instruction record and the decode helper.
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_AND    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] imm;
    logic        is_r;
    logic        is_i;
    logic        legal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.is_r   = (instr[6:0] == OPC_OP);
    d.is_i   = (instr[6:0] == OPC_OPIMM);
    d.legal  = d.is_r || d.is_i;
    // Shift-immediates carry only a 5-bit shamt; bit 30 selects arithmetic right shift.
    if (d.is_i && (d.funct3 == F3_SLL || d.funct3 == F3_SR)) begin
      d.imm = {27'b0, instr[24:20]};
    end else begin
      d.imm = {{20{instr[31]}}, instr[31:20]};
    end
    d.funct7 = instr[30] && (d.is_r || d.funct3 == F3_SR);
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: two combinational read ports, one debug read port,
// one synchronous write port; x0 is hard-wired to zero.
module alu_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] dbg_data_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] mem_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rs1_data_o = (rs1_addr_i == '0) ? '0 : mem_q[rs1_addr_i];
    rs2_data_o = (rs2_addr_i == '0) ? '0 : mem_q[rs2_addr_i];
    dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding a combinational ALU (ID -> EX with writeback).
// Define ALU_FWD_EN to bypass alu_result on RAW hazards instead of stalling.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic [XLEN-1:0]  alu_operand_a,
  output logic [XLEN-1:0]  alu_operand_b,
  output logic [2:0]       alu_funct3,
  output logic             alu_funct7,
  input  logic [XLEN-1:0]  alu_result,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  input  logic [4:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  dec_t            dec;
  logic [XLEN-1:0] rs1_data, rs2_data, imm_x;
  logic            haz_a, haz_b, fire, wb_en;

  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [XLEN-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  assign wb_en = ex_valid_q && (ex_rd_q != '0);

  alu_regfile #(.XLEN(XLEN)) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rs1_addr_i (dec.rs1),
    .rs2_addr_i (dec.rs2),
    .dbg_addr_i (dbg_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_data_o (dbg_data),
    .we_i       (wb_en),
    .waddr_i    (ex_rd_q),
    .wdata_i    (alu_result)
  );

  always_comb begin
    dec   = decode(in_instr);
    imm_x = XLEN'($signed(dec.imm));
    haz_a = dec.legal && wb_en && (ex_rd_q == dec.rs1);
    haz_b = dec.is_r && wb_en && (ex_rd_q == dec.rs2);

    ex_valid_d = 1'b0;
    ex_rd_d    = '0;
    op_a_d     = '0;
    op_b_d     = '0;
    f3_d       = '0;
    f7_d       = 1'b0;
    retired_d  = retired_q + CNT_W'(ex_valid_q);

`ifdef ALU_FWD_EN
    in_ready = 1'b1;
`else
    in_ready = !(haz_a || haz_b);
`endif
    fire      = in_valid && in_ready;
    illegal_d = fire && !dec.legal;

    if (fire && dec.legal) begin
      ex_valid_d = 1'b1;
      ex_rd_d    = dec.rd;
      f3_d       = dec.funct3;
      f7_d       = dec.funct7;
`ifdef ALU_FWD_EN
      // EX result has not reached the regfile yet; take it straight from the ALU.
      op_a_d = haz_a ? alu_result : rs1_data;
      op_b_d = dec.is_i ? imm_x : (haz_b ? alu_result : rs2_data);
`else
      op_a_d = rs1_data;
      op_b_d = dec.is_i ? imm_x : rs2_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      f3_q       <= '0;
      f7_q       <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign alu_funct3    = f3_q;
  assign alu_funct7    = f7_q;
  assign ex_valid      = ex_valid_q;
  assign ex_rd         = ex_rd_q;
  assign illegal       = illegal_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: behavioural ALU, architectural
// register model, directed scenarios plus randomized instruction streams.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        f7;
    logic [15:0] ret;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result, dbg_data;
  logic [2:0]  alu_funct3;
  logic        alu_funct7, ex_valid, illegal;
  logic [4:0]  ex_rd;
  logic [4:0]  dbg_addr = '0;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic [15:0] m_ret;

  alu_issue_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_funct3    (alu_funct3),
    .alu_funct7    (alu_funct7),
    .alu_result    (alu_result),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .illegal       (illegal),
    .retired       (retired),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  // Team ALU stand-in
  always_comb begin
    case (alu_funct3)
      3'd0: alu_result = alu_funct7 ? alu_operand_a - alu_operand_b : alu_operand_a + alu_operand_b;
      3'd1: alu_result = alu_operand_a << alu_operand_b[4:0];
      3'd2: alu_result = alu_operand_a & alu_operand_b;
      3'd3: alu_result = alu_operand_a | alu_operand_b;
      3'd4: alu_result = alu_operand_a ^ alu_operand_b;
      3'd5: alu_result = alu_funct7 ? 32'($signed(alu_operand_a) >>> alu_operand_b[4:0])
                                    : alu_operand_a >> alu_operand_b[4:0];
      default: alu_result = '0;
    endcase
  end

  function automatic logic [31:0] r_type(input logic alt, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] op2(input logic [31:0] ins);
    logic [31:0] y;
    if (ins[6:0] == 7'b0110011)                    y = m_rf[ins[24:20]];
    else if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) y = {27'b0, ins[24:20]};
    else                                           y = {{20{ins[31]}}, ins[31:20]};
    return y;
  endfunction

  function automatic logic alt_of(input logic [31:0] ins);
    return ins[30] && (ins[6:0] == 7'b0110011 || ins[14:12] == 3'd5);
  endfunction

  function automatic ex_t predict(input logic [31:0] ins);
    ex_t e;
    e.v   = 1'b1;
    e.rd  = ins[11:7];
    e.a   = m_rf[ins[19:15]];
    e.b   = op2(ins);
    e.f3  = ins[14:12];
    e.f7  = alt_of(ins);
    e.ret = m_ret;
    return e;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] ins);
    logic [31:0] x, y, r;
    x = m_rf[ins[19:15]];
    y = op2(ins);
    case (ins[14:12])
      3'd0: r = alt_of(ins) ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = alt_of(ins) ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic commit(input logic [31:0] ins);
    logic [31:0] r;
    r = exp_result(ins);
    if (ins[11:7] != 5'd0) m_rf[ins[11:7]] = r;
    m_ret = m_ret + 16'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ret = '0;
  endtask

  // Called at a negedge; returns at the negedge on which the instruction sits in EX.
  task automatic issue(input logic [31:0] ins, output ex_t o, output int st, output bit acc);
    in_valid = 1'b1;
    in_instr = ins;
    st = 0;
    #1;
    while (!in_ready && st < 8) begin
      @(negedge clk);
      st++;
      #1;
    end
    acc = in_ready;
    o = '0;
    if (!acc) begin
      in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    @(negedge clk);
    o = '{ex_valid, ex_rd, alu_operand_a, alu_operand_b, alu_funct3, alu_funct7, retired};
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_reg(input int a, output logic [31:0] d);
    dbg_addr = a[4:0];
    #1;
    d = dbg_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ex_valid, ex_rd, alu_operand_a, alu_operand_b, alu_funct3, alu_funct7, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rd=%0d a=%h b=%h f3=%0d f7=%b ill=%b ret=%0d expected all zero",
               ex_valid, ex_rd, alu_operand_a, alu_operand_b, alu_funct3, alu_funct7, illegal, retired);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(i, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg x%0d: got %h expected 0", i, d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_addi_add();
    logic [31:0] prog [3];
    logic [31:0] d;
    ex_t o, e;
    int st;
    bit acc;
    prog = '{i_type(12'd10, 5'd0, 3'd0, 5'd1), i_type(12'd20, 5'd0, 3'd0, 5'd2),
             r_type(1'b0, 5'd2, 5'd1, 3'd0, 5'd3)};
    foreach (prog[k]) begin
      e = predict(prog[k]);
      issue(prog[k], o, st, acc);
      checks++;
      if (!acc || o !== e) begin
        errors++;
        $display("FAIL t1_ex[%0d]: got acc=%b %h expected %h", k, acc, o, e);
      end
      commit(prog[k]);
      idle(1);
    end
    read_reg(3, d);
    checks++;
    if (d !== 32'd30) begin
      errors++;
      $display("FAIL t1_x3: got %0d expected 30", d);
    end
    checks++;
    if (retired !== 16'd3) begin
      errors++;
      $display("FAIL t1_retired: got %0d expected 3", retired);
    end
    @(negedge clk);
  endtask

  task automatic test_sub();
    logic [31:0] ins, d;
    ex_t o, e;
    int st;
    bit acc;
    ins = r_type(1'b1, 5'd1, 5'd3, 3'd0, 5'd4);
    e = predict(ins);
    issue(ins, o, st, acc);
    checks++;
    if (!acc || o.a !== 32'd30 || o.b !== 32'd10 || o.f7 !== 1'b1 || o !== e) begin
      errors++;
      $display("FAIL t2_sub_ex: got acc=%b a=%0d b=%0d f7=%b (%h) expected a=30 b=10 f7=1 (%h)",
               acc, o.a, o.b, o.f7, o, e);
    end
    commit(ins);
    idle(1);
    read_reg(4, d);
    checks++;
    if (d !== 32'd20) begin
      errors++;
      $display("FAIL t2_x4: got %0d expected 20", d);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] i1, i2, d;
    ex_t o, e;
    int st, exp_st;
    bit acc;
`ifdef ALU_FWD_EN
    exp_st = 0;
`else
    exp_st = 1;
`endif
    i1 = i_type(12'hFF0, 5'd0, 3'd0, 5'd5);
    i2 = i_type({7'b0100000, 5'd2}, 5'd5, 3'd5, 5'd6);
    e = predict(i1);
    issue(i1, o, st, acc);
    checks++;
    if (!acc || o !== e) begin
      errors++;
      $display("FAIL t3_addi_ex: got acc=%b %h expected %h", acc, o, e);
    end
    commit(i1);
    e = predict(i2);
    issue(i2, o, st, acc);
    checks++;
    if (!acc || o !== e || o.b !== 32'd2 || o.f7 !== 1'b1) begin
      errors++;
      $display("FAIL t3_srai_ex: got acc=%b %h expected %h", acc, o, e);
    end
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL t3_stall_cycles: got %0d expected %0d", st, exp_st);
    end
    commit(i2);
    idle(1);
    read_reg(6, d);
    checks++;
    if (d !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL t3_x6: got %h expected fffffffc", d);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    logic [31:0] i1, i2, d0, d7;
    logic [15:0] ret0;
    ex_t o, e;
    int st;
    bit acc;
    ret0 = m_ret;
    i1 = i_type(12'd5, 5'd0, 3'd0, 5'd0);
    i2 = r_type(1'b0, 5'd0, 5'd0, 3'd0, 5'd7);
    e = predict(i1);
    issue(i1, o, st, acc);
    checks++;
    if (!acc || o !== e) begin
      errors++;
      $display("FAIL t4_addi_x0_ex: got acc=%b %h expected %h", acc, o, e);
    end
    commit(i1);
    e = predict(i2);
    issue(i2, o, st, acc);
    checks++;
    if (!acc || o !== e || o.a !== 32'd0) begin
      errors++;
      $display("FAIL t4_add_x7_ex: got acc=%b %h expected %h", acc, o, e);
    end
    commit(i2);
    idle(1);
    read_reg(0, d0);
    read_reg(7, d7);
    checks++;
    if (d0 !== 32'd0 || d7 !== 32'd0) begin
      errors++;
      $display("FAIL t4_x0_x7: got x0=%h x7=%h expected 0 0", d0, d7);
    end
    checks++;
    if (retired !== ret0 + 16'd2) begin
      errors++;
      $display("FAIL t4_retired: got %0d expected %0d", retired, ret0 + 16'd2);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    in_valid = 1'b1;
    in_instr = 32'h0000_0073;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t5_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (illegal !== 1'b1 || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_pulse: got illegal=%b ex_valid=%b expected 1 0", illegal, ex_valid);
    end
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || ex_valid !== 1'b0 || retired !== m_ret) begin
      errors++;
      $display("FAIL t5_after: got illegal=%b ex_valid=%b ret=%0d expected 0 0 %0d",
               illegal, ex_valid, retired, m_ret);
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(i, d);
      checks++;
      if (d !== m_rf[i]) begin
        errors++;
        $display("FAIL t5_reg x%0d: got %h expected %h", i, d, m_rf[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] ins, d;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic        alt;
    ex_t o, e;
    int st;
    bit acc;
    for (int n = 0; n < 300; n++) begin
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      sh  = 5'($urandom);
      f3  = 3'($urandom_range(0, 5));
      alt = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ins = r_type(alt, rs2, rs1, f3, rd);
      end else begin
        if (f3 == 3'd1)      imm = {7'b0, sh};
        else if (f3 == 3'd5) imm = {1'b0, alt, 5'b0, sh};
        else                 imm = 12'($urandom);
        ins = i_type(imm, rs1, f3, rd);
      end
      e = predict(ins);
      issue(ins, o, st, acc);
      checks++;
      if (!acc || o !== e) begin
        errors++;
        $display("FAIL rand_ex[%0d] ins=%h: got acc=%b %h expected %h", n, ins, acc, o, e);
      end
      commit(ins);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);
    for (int i = 0; i < 32; i++) begin
      read_reg(i, d);
      checks++;
      if (d !== m_rf[i]) begin
        errors++;
        $display("FAIL rand_reg x%0d: got %h expected %h", i, d, m_rf[i]);
      end
    end
    checks++;
    if (retired !== m_ret) begin
      errors++;
      $display("FAIL rand_retired: got %0d expected %0d", retired, m_ret);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [31:0] ins, d;
    ex_t o;
    int st;
    bit acc;
    ins = r_type(1'b0, 5'd2, 5'd1, 3'd0, 5'd8);
    issue(ins, o, st, acc);
    checks++;
    if (!acc || o.v !== 1'b1 || o.rd !== 5'd8) begin
      errors++;
      $display("FAIL t6_pending: got acc=%b v=%b rd=%0d expected 1 1 8", acc, o.v, o.rd);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_rd, alu_operand_a, alu_operand_b, alu_funct3, alu_funct7, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL t6_async_clear: got v=%b rd=%0d a=%h b=%h ret=%0d expected all zero",
               ex_valid, ex_rd, alu_operand_a, alu_operand_b, retired);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      read_reg(i, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL t6_reg x%0d: got %h expected 0", i, d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_sub();
    test_back_to_back();
    test_x0();
    test_illegal();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
